// File: rtl/gpu_pkg.sv
// Shared types for the nano GPU: command layout, opcodes, rasteriser FSM
// states and the signed working type used by the Bresenham arithmetic.
package gpu_pkg;

  localparam int COORD_W = 9;
  localparam int COLOR_W = 8;
  localparam int SWORD_W = 11;

  typedef enum logic [1:0] {
    OP_LINE = 2'b00,
    OP_PLOT = 2'b01
  } opcode_e;

  // Bit layout of the 48-bit command word, MSB first.
  typedef struct packed {
    logic [1:0]         opcode;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [1:0]         rsvd;
    logic [COLOR_W-1:0] colour;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } state_e;

  // 11-bit signed: wide enough for +/-511 deltas and for 2*err.
  typedef logic signed [SWORD_W-1:0] sword_t;

  function automatic sword_t to_sword(input logic [COORD_W-1:0] c);
    return sword_t'({2'b00, c});
  endfunction

endpackage

// File: rtl/gpu_fb.sv
// Single-port frame buffer: synchronous write, registered read at the same
// address. Contents are never reset.
// Ports: clk, we, addr, data_in (write side), data_out (read data, 1 cycle).
module gpu_fb #(
  parameter int DEPTH  = 76800,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Addresses at or beyond DEPTH (possible when clipping is disabled) hit no
  // storage; the write is simply lost.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
    data_out <= mem[addr];
  end

endmodule

// File: rtl/gpu_line_raster.sv
// Bresenham line engine. start_i loads the endpoints (IDLE -> SETUP), SETUP
// derives deltas/steps/error in one cycle, DRAW emits one pixel per cycle and
// returns to IDLE after emitting the end point.
// Ports: clk_i, reset_i, start_i, x0_i/y0_i/x1_i/y1_i (endpoints),
//        busy_o, done_o (pulse with last pixel), pix_x_o/pix_y_o/pix_valid_o,
//        state_o (FSM state for debug).
module gpu_line_raster
  import gpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic               busy_o,
  output logic               done_o,
  output sword_t             pix_x_o,
  output sword_t             pix_y_o,
  output logic               pix_valid_o,
  output state_e             state_o
);

  state_e state_q, state_d;
  sword_t x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
  sword_t dx_q, dx_d, dy_q, dy_d, sx_q, sx_d, sy_q, sy_d, err_q, err_d;
  sword_t e2;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    err_d       = err_q;
    e2          = '0;
    done_o      = 1'b0;
    pix_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          x_d     = to_sword(x0_i);
          y_d     = to_sword(y0_i);
          x1_d    = to_sword(x1_i);
          y1_d    = to_sword(y1_i);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        dx_d    = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
        // dy is kept as the negated magnitude.
        dy_d    = (y1_q >= y_q) ? (y_q - y1_q) : (y1_q - y_q);
        sx_d    = (x_q < x1_q) ? 11'sd1 : -11'sd1;
        sy_d    = (y_q < y1_q) ? 11'sd1 : -11'sd1;
        err_d   = dx_d + dy_d;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        pix_valid_o = 1'b1;
        if (x_q == x1_q && y_q == y1_q) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // Both tests use e2 from the old error; both steps may apply.
          e2 = err_q <<< 1;
          if (e2 >= dy_q) begin
            err_d = err_d + dy_q;
            x_d   = x_q + sx_q;
          end
          if (e2 <= dx_q) begin
            err_d = err_d + dx_q;
            y_d   = y_q + sy_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign pix_x_o = x_q;
  assign pix_y_o = y_q;
  assign state_o = state_q;

endmodule

// File: rtl/nano_gpu_top.sv
// Minimal 2D raster GPU top: accepts 48-bit commands, rasterises lines and
// single-pixel plots one pixel per clock into the internal frame buffer `fb`.
// Ports: clk, reset (sync, active-high), cmd_data[47:0], cmd_valid, cmd_ready.
// Build option: define GPU_CLIP_EN to suppress writes for pixels outside
// FB_W x FB_H (those pixels still take their cycle). Without it the address
// is truncated to ADDR_W bits and may alias.
//
// Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready;
// cmd_data is only sampled on that edge. cmd_ready is high only while the
// engine is idle and reset is low; cmd_valid while busy is ignored and the
// upstream must hold its data until ready.
module nano_gpu_top
  import gpu_pkg::*;
#(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready
);

  cmd_t                cmd;
  logic                accept, start, busy, pix_valid, in_range;
  logic [COORD_W-1:0]  x1_sel, y1_sel;
  sword_t              pix_x, pix_y;
  logic [ADDR_W-1:0]   lin_addr;
  logic [COLOR_W-1:0]  colour_q, colour_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOR_W-1:0]  data_q, data_d;
  logic [1:0]          rsvd_unused;
  logic                raster_done_unused;
  state_e              raster_state_unused;
  logic [COLOR_W-1:0]  fb_rdata_unused;

  assign cmd         = cmd_t'(cmd_data);
  assign rsvd_unused = cmd.rsvd;
  assign cmd_ready   = !busy && !reset;
  assign accept      = cmd_valid && cmd_ready;
  // Opcodes 10/11 are accepted but never start the engine.
  assign start       = accept && (cmd.opcode == OP_LINE || cmd.opcode == OP_PLOT);
  // A plot is a degenerate line whose end point equals its start point.
  assign x1_sel      = (cmd.opcode == OP_PLOT) ? cmd.x0 : cmd.x1;
  assign y1_sel      = (cmd.opcode == OP_PLOT) ? cmd.y0 : cmd.y1;

  gpu_line_raster u_raster (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .x0_i        (cmd.x0),
    .y0_i        (cmd.y0),
    .x1_i        (x1_sel),
    .y1_i        (y1_sel),
    .busy_o      (busy),
    .done_o      (raster_done_unused),
    .pix_x_o     (pix_x),
    .pix_y_o     (pix_y),
    .pix_valid_o (pix_valid),
    .state_o     (raster_state_unused)
  );

  // Arithmetic done directly at ADDR_W bits, so the result is the linear
  // address truncated (modulo 2^ADDR_W).
  assign lin_addr = ADDR_W'(pix_y) * ADDR_W'(FB_W) + ADDR_W'(pix_x);

`ifdef GPU_CLIP_EN
  assign in_range = (pix_x < sword_t'(FB_W)) && (pix_y < sword_t'(FB_H));
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    colour_d = start ? cmd.colour : colour_q;
    we_d     = pix_valid && in_range;
    addr_d   = pix_valid ? lin_addr : addr_q;
    data_d   = pix_valid ? colour_q : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      colour_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      colour_q <= colour_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  gpu_fb #(
    .DEPTH  (FB_W * FB_H),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOR_W)
  ) fb (
    .clk      (clk),
    .we       (we_q),
    .addr     (addr_q),
    .data_in  (data_q),
    .data_out (fb_rdata_unused)
  );

endmodule

// File: tb/tb_nano_gpu_top.sv
// Directed bench for nano_gpu_top: drives commands, logs every frame buffer
// write seen at the fb instance, and compares against hand-computed lists.
module tb_nano_gpu_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;

  always #5 clk = ~clk;

  nano_gpu_top dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  logic [16:0] exp_q[$];

  always @(negedge clk) begin
    if (dut.fb.we === 1'b1) begin
      wr_addr_q.push_back(dut.fb.addr);
      wr_data_q.push_back(dut.fb.data_in);
      wr_cyc_q.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input int x0, input int y0,
                          input int x1, input int y1, input logic [7:0] col,
                          output int acc);
    logic [8:0] ax0, ay0, ax1, ay1;
    bit got;
    ax0 = x0[8:0]; ay0 = y0[8:0]; ax1 = x1[8:0]; ay1 = y1[8:0];
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    cmd_data  = {op, ax0, ay0, ax1, ay1, 2'b00, col};
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(output int lows);
    bit got;
    lows = 0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin got = 1'b1; break; end
      lows++;
    end
    if (!got) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_writes(input string tag, input logic [7:0] col, input int acc);
    int n;
    check({tag, "_count"}, wr_addr_q.size(), exp_q.size());
    n = (wr_addr_q.size() < exp_q.size()) ? wr_addr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(col));
      check($sformatf("%s_cyc%0d", tag, i), wr_cyc_q[i], acc + 2 + i);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input int x0, input int y0,
                         input int x1, input int y1, input logic [7:0] col, input int exp_lows);
    int acc, lows;
    send_cmd(op, x0, y0, x1, y1, col, acc);
    wait_idle(lows);
    check({tag, "_busy"}, lows, exp_lows);
    repeat (3) @(negedge clk);
    expect_writes(tag, col, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    // Reset for exactly one rising edge.
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_we", 32'(dut.fb.we), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Diagonal line (0,0)->(5,5).
    exp_q = '{17'd0, 17'd321, 17'd642, 17'd963, 17'd1284, 17'd1605};
    run_cmd("diag", 2'b00, 0, 0, 5, 5, 8'hFF, 7);

    // Horizontal line forward and reverse.
    exp_q = '{17'd970, 17'd971, 17'd972, 17'd973};
    run_cmd("hfwd", 2'b00, 10, 3, 13, 3, 8'h12, 5);
    exp_q = '{17'd973, 17'd972, 17'd971, 17'd970};
    run_cmd("hrev", 2'b00, 13, 3, 10, 3, 8'h12, 5);

    // Plot at the far corner; x1/y1 carry junk that must be ignored.
    exp_q = '{17'd76799};
    run_cmd("plot", 2'b01, 319, 239, 7, 9, 8'hA5, 2);

    // Degenerate line behaves like a plot.
    exp_q = '{17'd1610};
    run_cmd("degen", 2'b00, 10, 5, 10, 5, 8'h3C, 2);

    // Steep line (2,0)->(3,4).
    exp_q = '{17'd2, 17'd322, 17'd643, 17'd963, 17'd1283};
    run_cmd("steep", 2'b00, 2, 0, 3, 4, 8'h07, 6);

    // NOP: no write, ready never drops.
    run_cmd("nop", 2'b11, 1, 1, 50, 50, 8'h55, 0);

    // Line running off the right edge.
`ifdef GPU_CLIP_EN
    exp_q = '{17'd318, 17'd319};
`else
    exp_q = '{17'd318, 17'd319, 17'd320, 17'd321, 17'd322};
`endif
    run_cmd("edge", 2'b00, 318, 0, 322, 0, 8'hC3, 6);

    // Reset during the third pixel of a 10-pixel line.
    exp_q = '{17'd3200, 17'd3201};
    send_cmd(2'b00, 0, 10, 9, 10, 8'h99, acc);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    repeat (12) @(negedge clk);
    check("abort_ready_hold", 32'(cmd_ready), 32'd1);
    expect_writes("abort", 8'h99, acc);

    // Normal operation resumes.
    exp_q = '{17'd321};
    run_cmd("resume", 2'b01, 1, 1, 0, 0, 8'h33, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
